regfile_sb: RTL and testbench

Parametrised register file with a per-register pending (scoreboard) bit. It is the generalised successor of the fixed 16×32 pipeline register file. The block provides two combinational read ports, one clocked write-back port and one issue port that marks a destination register as pending until its write-back lands. It sits in the decode stage: decode reads operands and the busy flags to decide stalls, and write-back drives the write port.

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 96 +++++++++
 tb/tb_regfile_sb.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bundle of the regfile_sb read, issue and write-back signals.
// The master modport drives addresses/enables; the slave modport is the register file.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              rs_busy;
  logic              rt_busy;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              reg_write;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W:0]   pend_cnt;
  logic              iss_dup;

  modport master (
    output rs, rt, iss_en, iss_addr, reg_write, rd, write_data,
    input  A, B, rs_busy, rt_busy, pend_cnt, iss_dup
  );

  modport slave (
    input  rs, rt, iss_en, iss_addr, reg_write, rd, write_data,
    output A, B, rs_busy, rt_busy, pend_cnt, iss_dup
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, two combinational read ports.
// Optional macro RF_BYPASS_EN forwards same-cycle write-back data and busy clears to the read ports.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] reg_file_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  iss_hit;
  logic [ADDR_W:0]   pend_cnt_reg;
  logic [ADDR_W:0]   pend_cnt_next;
  logic              iss_dup_reg;
  logic              wr_ok;
  logic              iss_ok;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign wr_ok  = rf.reg_write && !((ZERO_REG != 0) && (rf.rd == '0));
  assign iss_ok = rf.iss_en && !((ZERO_REG != 0) && (rf.iss_addr == '0));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign wr_hit[gi]    = wr_ok && (rf.rd == ADDR_W'(gi));
      assign iss_hit[gi]   = iss_ok && (rf.iss_addr == ADDR_W'(gi));
      // Issue wins over a same-address write-back: the new producer is still in flight.
      assign busy_next[gi] = iss_hit[gi] | (busy_reg[gi] & ~wr_hit[gi]);
    end
  endgenerate

  always_comb begin
    pend_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_next = pend_cnt_next + (ADDR_W + 1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg     <= '0;
      pend_cnt_reg <= '0;
      iss_dup_reg  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_file_reg[i] <= '0;
      end
    end else begin
      busy_reg     <= busy_next;
      pend_cnt_reg <= pend_cnt_next;
      if (iss_ok && busy_reg[rf.iss_addr]) begin
        iss_dup_reg <= 1'b1;
      end
      if (wr_ok) begin
        reg_file_reg[rf.rd] <= rf.write_data;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] raddr;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign raddr = (gi == 0) ? rf.rs : rf.rt;

      always_comb begin
        data = reg_file_reg[raddr];
        busy = busy_reg[raddr];
`ifdef RF_BYPASS_EN
        if (wr_ok && (rf.rd == raddr)) begin
          data = rf.write_data;
          busy = iss_ok && (rf.iss_addr == raddr);
        end
`endif
        if ((ZERO_REG != 0) && (raddr == '0)) begin
          data = '0;
          busy = 1'b0;
        end
      end
    end
  endgenerate

  assign rf.A        = g_rd[0].data;
  assign rf.B        = g_rd[1].data;
  assign rf.rs_busy  = g_rd[0].busy;
  assign rf.rt_busy  = g_rd[1].busy;
  assign rf.pend_cnt = pend_cnt_reg;
  assign rf.iss_dup  = iss_dup_reg;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios then random traffic against a
// behavioural model of registers, busy flags and the sticky duplicate-issue flag.
module tb_regfile_sb;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 16;
  localparam int ZERO_REG = 1;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf ();

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) dut (
    .clk(clk),
    .rst(rst),
    .rf (rf)
  );

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        ab;
    logic        bb;
    logic [4:0]  cnt;
    logic        dup;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_reg [DEPTH];
  bit          m_busy [DEPTH];
  bit          m_dup;
  int          n_checks = 0;
  int          n_errors = 0;
  int          txn_id   = 0;

  function automatic bit is_zero_reg(input logic [3:0] a);
    return (ZERO_REG != 0) && (a == 4'd0);
  endfunction

  function automatic logic [31:0] exp_data(input logic [3:0] a, input bit we,
                                            input logic [3:0] wa, input logic [31:0] wd);
    if (is_zero_reg(a)) return 32'd0;
    if (BYP && we && wa == a) return wd;
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input logic [3:0] a, input bit we, input logic [3:0] wa,
                                  input bit ie, input logic [3:0] ia);
    if (is_zero_reg(a)) return 1'b0;
    if (BYP && we && wa == a) return ie && ia == a;
    return m_busy[a];
  endfunction

  function automatic int model_pending();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic step(input bit r, input logic [3:0] s, input logic [3:0] t,
                      input bit ie, input logic [3:0] ia,
                      input bit we, input logic [3:0] wa, input logic [31:0] wd);
    exp_t e;
    bit   w_ok, i_ok, was_busy;
    @(negedge clk);
    rst = r;
    rf.rs = s;
    rf.rt = t;
    rf.iss_en = ie;
    rf.iss_addr = ia;
    rf.reg_write = we;
    rf.rd = wa;
    rf.write_data = wd;
    #1;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  = 32'd0;
        m_busy[i] = 1'b0;
      end
      m_dup = 1'b0;
    end
    e.id  = txn_id;
    e.a   = exp_data(s, we, wa, wd);
    e.b   = exp_data(t, we, wa, wd);
    e.ab  = exp_busy(s, we, wa, ie, ia);
    e.bb  = exp_busy(t, we, wa, ie, ia);
    e.cnt = 5'(model_pending());
    e.dup = m_dup;
    sb_q.push_back(e);
    txn_id++;
    if (!r) begin
      w_ok     = we && !is_zero_reg(wa);
      i_ok     = ie && !is_zero_reg(ia);
      was_busy = m_busy[ia];
      if (w_ok) begin
        m_reg[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (i_ok) begin
        if (was_busy) m_dup = 1'b1;
        m_busy[ia] = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s txn %0d: got %h expected %h", name, id, got, want);
    end
  endtask

  // Monitor: the DUT presents a fresh output every cycle; compare after the driver has pushed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("txn %0d rs=%0d A=%h rs_busy=%0b rt=%0d B=%h rt_busy=%0b pend=%0d dup=%0b",
                 e.id, rf.rs, rf.A, rf.rs_busy, rf.rt, rf.B, rf.rt_busy, rf.pend_cnt, rf.iss_dup);
        check("A", e.id, rf.A, e.a);
        check("B", e.id, rf.B, e.b);
        check("rs_busy", e.id, 32'(rf.rs_busy), 32'(e.ab));
        check("rt_busy", e.id, 32'(rf.rt_busy), 32'(e.bb));
        check("pend_cnt", e.id, 32'(rf.pend_cnt), 32'(e.cnt));
        check("iss_dup", e.id, 32'(rf.iss_dup), 32'(e.dup));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rf.rs = '0; rf.rt = '0; rf.iss_en = 1'b0; rf.iss_addr = '0;
    rf.reg_write = 1'b0; rf.rd = '0; rf.write_data = '0;
    // Reset and idle
    step(1, 4'd1, 4'd2, 0, 4'd0, 0, 4'd0, 32'd0);
    step(0, 4'd1, 4'd2, 0, 4'd0, 0, 4'd0, 32'd0);
    // Basic write/read, register 0 write ignored
    step(0, 4'd7, 4'd0, 0, 4'd0, 1, 4'd7, 32'hBEFF556A);
    step(0, 4'd7, 4'd0, 0, 4'd0, 1, 4'd0, 32'h00001234);
    step(0, 4'd0, 4'd7, 0, 4'd0, 0, 4'd0, 32'd0);
    // Issue r5 then write it back
    step(0, 4'd5, 4'd7, 1, 4'd5, 0, 4'd0, 32'd0);
    step(0, 4'd5, 4'd7, 0, 4'd0, 1, 4'd5, 32'h000000A0);
    step(0, 4'd5, 4'd5, 0, 4'd0, 0, 4'd0, 32'd0);
    // Issue and write-back collide on r4
    step(0, 4'd4, 4'd5, 1, 4'd4, 1, 4'd4, 32'h000000B1);
    step(0, 4'd4, 4'd5, 0, 4'd0, 0, 4'd0, 32'd0);
    // Duplicate issue to r11, and issue to r0 ignored
    step(0, 4'd11, 4'd4, 1, 4'd11, 0, 4'd0, 32'd0);
    step(0, 4'd11, 4'd0, 1, 4'd11, 0, 4'd0, 32'd0);
    step(0, 4'd11, 4'd0, 1, 4'd0, 0, 4'd0, 32'd0);
    step(0, 4'd0, 4'd11, 1, 4'd0, 0, 4'd0, 32'd0);
    // Write-back to busy r10 while reading it
    step(0, 4'd10, 4'd11, 1, 4'd10, 0, 4'd0, 32'd0);
    step(0, 4'd10, 4'd10, 0, 4'd0, 1, 4'd10, 32'h0FAFF7EF);
    step(0, 4'd10, 4'd10, 0, 4'd0, 0, 4'd0, 32'd0);
    // Same-cycle bypass with a re-issue of the read register
    step(0, 4'd10, 4'd4, 1, 4'd4, 1, 4'd4, 32'h00C0FFEE);
    // Mid-run asynchronous reset, then readback
    step(1, 4'd7, 4'd4, 0, 4'd0, 0, 4'd0, 32'd0);
    step(0, 4'd7, 4'd10, 0, 4'd0, 0, 4'd0, 32'd0);
    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ia, wa;
      bit ie, we, r;
      ia = 4'($urandom_range(0, 15));
      wa = 4'($urandom_range(0, 15));
      ie = ($urandom_range(0, 2) == 0);
      we = ($urandom_range(0, 1) == 1);
      r  = (n == 200);
      if (r) begin
        ie = 1'b0;
        we = 1'b0;
      end
      step(r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ie, ia, we, wa, $urandom);
    end
    @(negedge clk);
    #5;
    check("queue_drained", txn_id, 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
